reduce_stim_checker: RTL
========================

REDUCE_STIM_CHECKER -- requirements
Module: reduce_stim_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4: width of the in1/in2 stimulus buses (legal range 2..8).
REQ-002 SHALL have parameter LATENCY, default 1: cycles from the stimulus being driven to the DUT response being sampled (legal range 1..4).
REQ-003 SHALL have port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port ASYNCRESET, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a sweep.
REQ-006 SHALL have port in1, output, WIDTH: stimulus A to the DUT.
REQ-007 SHALL have port in2, output, WIDTH: stimulus B to the DUT.
REQ-008 SHALL have port vec_valid, output, 1: in1/in2 carry a live vector this cycle.
REQ-009 SHALL have port out, input, 1: DUT response.
REQ-010 SHALL have port busy, output, 1: high in RUN or DRAIN.
REQ-011 SHALL have port done, output, 1: high in DONE.
REQ-012 SHALL have port pass, output, 1: high in DONE only when err_count is 0.
REQ-013 SHALL have port err_count, output, 8: number of mismatches in the sweep, saturating at 255.
REQ-014 SHALL have port first_err_vec, output, WIDTH: in1 value of the first mismatching vector; 0 if none.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN, DRAIN, DONE.
REQ-016 From IDLE or DONE, start=1 SHALL enter RUN next cycle, clear err_count and first_err_vec, and zero the vector index.
REQ-017 start SHALL be ignored while in RUN or DRAIN.
REQ-018 In RUN, each cycle SHALL drive in1 = index, in2 = bitwise NOT of index, vec_valid = 1, then increment index.
REQ-019 RUN SHALL last exactly 2^WIDTH cycles (index 0 .. 2^WIDTH-1), then enter DRAIN.
REQ-020 Outside RUN, in1, in2 and vec_valid SHALL be 0.
REQ-021 Expected response SHALL be (OR-reduce in1) AND (AND-reduce in1), computed when the vector is driven.
REQ-022 The expected bit, vec_valid and in1 SHALL be delayed LATENCY cycles; out SHALL be compared only when delayed valid is 1.
REQ-023 A mismatch SHALL increment err_count, saturating at 255; the first mismatch of a sweep SHALL latch delayed in1 into first_err_vec.
REQ-024 DRAIN SHALL last exactly LATENCY cycles, then enter DONE; the final comparison occurs in the last DRAIN cycle.
REQ-025 DONE SHALL hold err_count, first_err_vec and pass stable until the next accepted start.
REQ-026 With start held high continuously, a new sweep SHALL begin on the cycle after DONE is entered.

Reset
REQ-027 ASYNCRESET=1 SHALL immediately force IDLE, index 0, delay line cleared, and all outputs 0, including mid-sweep.
REQ-028 After deassertion, the first action SHALL be a start accepted in IDLE; no stale delayed compare SHALL occur.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, RUN, DRAIN, DONE) and the constants ERR_W=8 and ERR_MAX=255.
REQ-030 The LATENCY-deep delay of {valid, expected, in1} SHALL be one sub-module, reduce_ref_pipe, parameterised by WIDTH and LATENCY.

Verification
REQ-031 Correct DUT model (out = expected delayed 1), WIDTH=4, LATENCY=1: start at cycle 0 -> RUN cycles 1-16, DRAIN cycle 17, done=1 from cycle 18, pass=1, err_count=0.
REQ-032 DUT stuck at 0 -> err_count=1, first_err_vec=4'hF, pass=0.
REQ-033 DUT stuck at 1 -> err_count=15, first_err_vec=4'h0, pass=0.
REQ-034 start pulsed again at RUN index 7 -> ignored; the sweep completes with the same timing as REQ-031.
REQ-035 ASYNCRESET asserted mid-cycle at index 5 -> outputs 0 immediately; a restart then yields pass=1 with a correct DUT.
REQ-036 LATENCY=3 with a matching 3-cycle DUT -> DRAIN is 3 cycles and pass=1; the same DUT with LATENCY=1 gives err_count>0.

Source files
------------

// File: rtl/reduce_stim_checker_pkg.sv
// Shared state encoding and error-counter constants for the reduce stimulus checker.
package reduce_stim_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

endpackage

// File: rtl/reduce_ref_pipe.sv
// LATENCY-deep delay line carrying {valid, expected, in1} so the reference lines up with the DUT response.
module reduce_ref_pipe #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             expected,
    input  logic [WIDTH-1:0] vec,
    output logic             dly_valid,
    output logic             dly_expected,
    output logic [WIDTH-1:0] dly_vec
);

    localparam int SW = WIDTH + 2;

    logic [SW-1:0] stages [LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= {valid, expected, vec};
            for (int i = 1; i < LATENCY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign {dly_valid, dly_expected, dly_vec} = stages[LATENCY-1];

endmodule

// File: rtl/reduce_stim_checker.sv
// Sweeps every in1 value (in2 = ~in1) into a reduce DUT and checks out against
// (|in1) & (&in1) after LATENCY cycles, reporting error count and first failing vector.
module reduce_stim_checker
    import reduce_stim_checker_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             start,
    output logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] in2,
    output logic             vec_valid,
    input  logic             out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] first_err_vec,
    output state_t           state
);

    localparam logic [WIDTH-1:0] LAST_IDX   = '1;
    localparam logic [WIDTH-1:0] LAST_DRAIN = WIDTH'(LATENCY - 1);

    state_t           state_next;
    logic [WIDTH-1:0] index;
    logic             expected;
    logic             dly_valid;
    logic             dly_expected;
    logic [WIDTH-1:0] dly_vec;
    logic             mismatch;
    logic             accept;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = RUN;
            RUN:        if (index == LAST_IDX) state_next = DRAIN;
            DRAIN:      if (index == LAST_DRAIN) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // index counts vectors in RUN and drain cycles in DRAIN; every state change restarts it.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            index <= '0;
        end else if (state_next != state) begin
            index <= '0;
        end else if (state == RUN || state == DRAIN) begin
            index <= index + WIDTH'(1);
        end
    end

    // vec_valid qualifies in1/in2 for one cycle each; the DUT has no ready, so every vector is consumed.
    assign vec_valid = (state == RUN);
    assign in1       = vec_valid ? index : '0;
    assign in2       = vec_valid ? ~index : '0;
    assign expected  = (|in1) & (&in1);

    reduce_ref_pipe #(
        .WIDTH  (WIDTH),
        .LATENCY(LATENCY)
    ) u_pipe (
        .clk         (CLK),
        .rst         (ASYNCRESET),
        .valid       (vec_valid),
        .expected    (expected),
        .vec         (in1),
        .dly_valid   (dly_valid),
        .dly_expected(dly_expected),
        .dly_vec     (dly_vec)
    );

    assign accept   = (state == IDLE || state == DONE) && start;
    assign mismatch = dly_valid && (out != dly_expected);

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            err_count     <= '0;
            first_err_vec <= '0;
        end else if (accept) begin
            err_count     <= '0;
            first_err_vec <= '0;
        end else if (mismatch) begin
            if (err_count != ERR_MAX) err_count <= err_count + 8'd1;
            if (err_count == '0) first_err_vec <= dly_vec;
        end
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (err_count == '0);

endmodule
